// File: rtl/fmeter_pkg.sv
// Shared definitions for the frequency meter display.
//   BCD_W      : width of one BCD digit
//   SEG_*      : 7-segment patterns {g,f,e,d,c,b,a}, active-high
//   state_e    : gate/latch FSM encoding
package fmeter_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

endpackage

// File: rtl/sevenseg_dec.sv
// BCD to 7-segment decoder, purely combinational.
//   bcd_i : 4-bit BCD digit
//   seg_o : segments {g,f,e,d,c,b,a}, active-high; codes 10-15 are blank
module sevenseg_dec
  import fmeter_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [6:0]       seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/freq_meter_disp.sv
// Frequency meter: counts rising edges of the divided clock fin over a gate
// window of GATE_CYCLES CLK cycles, latches the count as NDIG BCD digits and
// scans them onto a multiplexed 7-segment display.
//   CLK     : system clock
//   RSTN    : asynchronous active-low reset
//   enable  : measurement enable
//   fin     : divided clock, asynchronous to CLK
//   dispout : segments {dp,g,f,e,d,c,b,a}, dp shows the overflow flag
//   digsel  : one-hot digit select, rotates every REFRESH_DIV cycles
//   valid   : one-cycle pulse when a new result is latched
//   ovf     : latched result saturated at all-9s
// Optional build macro FMETER_LZB_EN enables leading-zero blanking.
module freq_meter_disp
  import fmeter_pkg::*;
#(
  parameter int GATE_CYCLES = 100000,
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            enable,
  input  logic            fin,
  output logic [7:0]      dispout,
  output logic [NDIG-1:0] digsel,
  output logic            valid,
  output logic            ovf
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW = NDIG * BCD_W;

  logic            sync1_q, sync2_q, hist_q, fin_edge;
  state_e          state_q, state_d;
  logic [GW-1:0]   gate_q, gate_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc, result_q, result_d;
  logic            sat_q, sat_d, ovf_q, ovf_d, all9, carry;
  logic            gate_term, count_en, latch_en;
  logic [RW-1:0]   scan_q, scan_d;
  logic [NDIG-1:0] digsel_q, digsel_d;
  logic [BCD_W-1:0] sel_bcd;
  logic [6:0]      seg;
  logic            blank;

  // ---- input capture: 2-flop synchronizer plus history flop
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= fin;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign fin_edge  = sync2_q & ~hist_q;
  assign gate_term = (gate_q == GW'(GATE_CYCLES - 1));

  // ---- FSM: state register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_COUNT;
      ST_COUNT: begin
        if (!enable)        state_d = ST_IDLE;
        else if (gate_term) state_d = ST_LATCH;
      end
      ST_LATCH: state_d = enable ? ST_COUNT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs
  always_comb begin
    count_en = (state_q == ST_COUNT) && enable;
    latch_en = (state_q == ST_LATCH);
    valid    = latch_en;
  end

  // BCD increment with ripple carry resolved in one cycle; all9 flags the
  // saturating case so the counter can hold instead of wrapping to zero.
  always_comb begin
    cnt_inc = cnt_q;
    carry   = 1'b1;
    all9    = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_q[i*BCD_W +: BCD_W] != BCD_W'(9)) all9 = 1'b0;
      if (carry) begin
        if (cnt_q[i*BCD_W +: BCD_W] == BCD_W'(9)) begin
          cnt_inc[i*BCD_W +: BCD_W] = '0;
        end else begin
          cnt_inc[i*BCD_W +: BCD_W] = cnt_q[i*BCD_W +: BCD_W] + BCD_W'(1);
          carry = 1'b0;
        end
      end
    end
  end

  // Counters fall back to zero whenever not counting, which also discards a
  // partial window when enable drops. An edge seen during LATCH seeds the
  // next window with 1 so no edge is lost across the window boundary.
  always_comb begin
    gate_d   = '0;
    cnt_d    = '0;
    sat_d    = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    if (count_en) begin
      gate_d = gate_term ? '0 : gate_q + GW'(1);
      cnt_d  = cnt_q;
      sat_d  = sat_q;
      if (fin_edge) begin
        if (all9) sat_d = 1'b1;
        else      cnt_d = cnt_inc;
      end
    end else if (latch_en) begin
      cnt_d    = fin_edge ? CW'(1) : '0;
      result_d = cnt_q;
      ovf_d    = sat_q;
    end
  end

  // ---- display scan: digsel rotates left every REFRESH_DIV cycles
  always_comb begin
    scan_d   = scan_q + RW'(1);
    digsel_d = digsel_q;
    if (scan_q == RW'(REFRESH_DIV - 1)) begin
      scan_d   = '0;
      digsel_d = (digsel_q << 1) | (digsel_q >> (NDIG - 1));
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      gate_q   <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      scan_q   <= '0;
      digsel_q <= NDIG'(1);
    end else begin
      gate_q   <= gate_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      scan_q   <= scan_d;
      digsel_q <= digsel_d;
    end
  end

  always_comb begin
    sel_bcd = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (digsel_q[i]) sel_bcd = result_q[i*BCD_W +: BCD_W];
    end
  end

  sevenseg_dec u_dec (
    .bcd_i (sel_bcd),
    .seg_o (seg)
  );

`ifdef FMETER_LZB_EN
  // A digit is blank when it and every more significant digit are zero;
  // digit 0 is excluded so a zero result still shows "0".
  logic zero_above;
  always_comb begin
    blank      = 1'b0;
    zero_above = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      zero_above = zero_above & (result_q[i*BCD_W +: BCD_W] == '0);
      if (digsel_q[i] && zero_above) blank = 1'b1;
    end
  end
`else
  assign blank = 1'b0;
`endif

  assign dispout = {ovf_q, blank ? SEG_BLANK : seg};
  assign digsel  = digsel_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_freq_meter_disp.sv
module tb_freq_meter_disp;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       enable = 1'b0;
  logic       en2 = 1'b0;
  logic       fin = 1'b0;
  logic [7:0] dispout, dispout2;
  logic [3:0] digsel;
  logic [1:0] digsel2;
  logic       valid, valid2, ovf, ovf2;

  int checks = 0;
  int failures = 0;
  int fin_half = 0;
  int ph_cnt = 0;

  always #5 CLK = ~CLK;

  freq_meter_disp #(.GATE_CYCLES(1000), .NDIG(4), .REFRESH_DIV(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .enable(enable), .fin(fin),
    .dispout(dispout), .digsel(digsel), .valid(valid), .ovf(ovf)
  );

  // Small instance so saturation is reachable in a short window.
  freq_meter_disp #(.GATE_CYCLES(600), .NDIG(2), .REFRESH_DIV(4)) u_ovf (
    .CLK(CLK), .RSTN(RSTN), .enable(en2), .fin(fin),
    .dispout(dispout2), .digsel(digsel2), .valid(valid2), .ovf(ovf2)
  );

  // Free-running fin generator: toggles every fin_half cycles when nonzero.
  always @(negedge CLK) begin
    if (fin_half > 0) begin
      if (ph_cnt >= fin_half - 1) begin
        fin = ~fin;
        ph_cnt = 0;
      end else begin
        ph_cnt++;
      end
    end else begin
      ph_cnt = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 8'h3F;
      4'd1: seg_of = 8'h06;
      4'd2: seg_of = 8'h5B;
      4'd3: seg_of = 8'h4F;
      4'd4: seg_of = 8'h66;
      4'd5: seg_of = 8'h6D;
      4'd6: seg_of = 8'h7D;
      4'd7: seg_of = 8'h07;
      4'd8: seg_of = 8'h7F;
      4'd9: seg_of = 8'h6F;
      default: seg_of = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_disp(input logic [15:0] bcd, input int k, input logic dp);
    logic [3:0]  d;
    logic [15:0] hi;
    logic [7:0]  r;
    d  = bcd[4*k +: 4];
    hi = bcd >> (4 * k);
    r  = seg_of(d);
`ifdef FMETER_LZB_EN
    if (k != 0 && hi == 16'h0) r = 8'h00;
`else
    if (hi == 16'hFFFF) r = 8'h00;
`endif
    r[7] = dp;
    return r;
  endfunction

  // Counts posedges until valid is seen (sampled 1 time unit after the edge).
  task automatic wait_valid(input int bound, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < bound) begin
      @(posedge CLK);
      #1;
      n++;
      if (valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_display(input logic [15:0] bcd, input logic dp, input string tag);
    logic [3:0] sel;
    logic [7:0] e;
    int t;
    @(posedge CLK);
    for (int k = 0; k < 4; k++) begin
      sel = 4'b0001 << k;
      e = exp_disp(bcd, k, dp);
      @(negedge CLK);
      t = 0;
      while (digsel !== sel && t < 40) begin
        @(negedge CLK);
        t++;
      end
      checks++;
      if (digsel !== sel) begin
        failures++;
        $display("FAIL %s_sel%0d: digsel=%b expected %b", tag, k, digsel, sel);
      end else if (dispout !== e) begin
        failures++;
        $display("FAIL %s_dig%0d: dispout=%h expected %h", tag, k, dispout, e);
      end
    end
  endtask

  task automatic test_reset;
    RSTN = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (dispout !== 8'h3F || digsel !== 4'b0001 || valid !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset: dispout=%h digsel=%b valid=%b ovf=%b expected 3f 0001 0 0",
               dispout, digsel, valid, ovf);
    end
    checks++;
    if (dispout2 !== 8'h3F || digsel2 !== 2'b01 || ovf2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_small: dispout=%h digsel=%b ovf=%b expected 3f 01 0",
               dispout2, digsel2, ovf2);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_steady;
    int n;
    bit ok;
    fin_half = 5;
    @(negedge CLK);
    enable = 1'b1;
    wait_valid(1100, n, ok);
    checks++;
    if (!ok || n != 1001) begin
      failures++;
      $display("FAIL steady_latency: cycles=%0d expected 1001", n);
    end
    wait_valid(1100, n, ok);
    checks++;
    if (!ok || n != 1001) begin
      failures++;
      $display("FAIL steady_period: cycles=%0d expected 1001", n);
    end
    @(negedge CLK);
    enable = 1'b0;
    repeat (5) @(negedge CLK);
    enable = 1'b1;
    wait_valid(1100, n, ok);
    checks++;
    if (!ok || n != 1001) begin
      failures++;
      $display("FAIL steady_restart: cycles=%0d expected 1001", n);
    end
    @(negedge CLK);
    enable = 1'b0;
    check_display(16'h0100, 1'b0, "steady");
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL steady_ovf: ovf=%b expected 0", ovf);
    end
  endtask

  task automatic test_abort;
    int n;
    int seen;
    bit ok;
    @(negedge CLK);
    enable = 1'b1;
    repeat (500) @(posedge CLK);
    @(negedge CLK);
    enable = 1'b0;
    seen = 0;
    repeat (1500) begin
      @(posedge CLK);
      #1;
      if (valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_novalid: pulses=%0d expected 0", seen);
    end
    check_display(16'h0100, 1'b0, "abort_hold");
    fin_half = 10;
    repeat (10) @(negedge CLK);
    enable = 1'b1;
    wait_valid(1100, n, ok);
    checks++;
    if (!ok || n != 1001) begin
      failures++;
      $display("FAIL abort_reenable: cycles=%0d expected 1001", n);
    end
    @(negedge CLK);
    enable = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL valid_width: valid=%b expected 0", valid);
    end
    check_display(16'h0050, 1'b0, "abort_full");
  endtask

  task automatic test_boundary;
    int n;
    bit ok;
    fin_half = 0;
    @(negedge CLK);
    fin = 1'b0;
    repeat (10) @(negedge CLK);
    // Pulse timed so its edge lands on the terminal COUNT cycle.
    enable = 1'b1;
    repeat (998) @(posedge CLK);
    @(negedge CLK);
    fin = 1'b1;
    repeat (2) @(negedge CLK);
    fin = 1'b0;
    wait_valid(10, n, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL term_valid: valid=0 expected 1");
    end
    @(negedge CLK);
    enable = 1'b0;
    check_display(16'h0001, 1'b0, "term_edge");
    repeat (10) @(negedge CLK);
    // Pulse timed so its edge lands on the LATCH cycle.
    enable = 1'b1;
    repeat (999) @(posedge CLK);
    @(negedge CLK);
    fin = 1'b1;
    wait_valid(10, n, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL latch_valid: valid=0 expected 1");
    end
    @(negedge CLK);
    fin = 1'b0;
    check_display(16'h0000, 1'b0, "latch_old");
    wait_valid(1100, n, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL latch_valid2: valid=0 expected 1");
    end
    @(negedge CLK);
    enable = 1'b0;
    check_display(16'h0001, 1'b0, "latch_new");
  endtask

  task automatic test_scan;
    int n;
    int t;
    bit ok;
    logic [3:0] prev;
    logic [3:0] e;
    @(negedge CLK);
    enable = 1'b1;
    repeat (42) begin
      fin = 1'b1;
      repeat (5) @(negedge CLK);
      fin = 1'b0;
      repeat (5) @(negedge CLK);
    end
    wait_valid(1100, n, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL scan_valid: valid=0 expected 1");
    end
    @(negedge CLK);
    enable = 1'b0;
    check_display(16'h0042, 1'b0, "scan42");
    prev = digsel;
    @(negedge CLK);
    t = 0;
    while (!(prev == 4'b1000 && digsel == 4'b0001) && t < 40) begin
      prev = digsel;
      @(negedge CLK);
      t++;
    end
    for (int c = 0; c < 16; c++) begin
      e = 4'b0001 << (c / 4);
      checks++;
      if (digsel !== e) begin
        failures++;
        $display("FAIL scan_seq%0d: digsel=%b expected %b", c, digsel, e);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_overflow;
    int t;
    logic [1:0] sel;
    fin_half = 2;
    @(negedge CLK);
    en2 = 1'b1;
    t = 0;
    while (t < 700) begin
      @(posedge CLK);
      #1;
      t++;
      if (valid2) break;
    end
    checks++;
    if (!valid2) begin
      failures++;
      $display("FAIL ovf_valid: valid=0 expected 1");
    end
    @(negedge CLK);
    en2 = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (ovf2 !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flag: ovf=%b expected 1", ovf2);
    end
    for (int k = 0; k < 2; k++) begin
      sel = 2'b01 << k;
      t = 0;
      while (digsel2 !== sel && t < 20) begin
        @(negedge CLK);
        t++;
      end
      checks++;
      if (digsel2 !== sel || dispout2 !== 8'hEF) begin
        failures++;
        $display("FAIL ovf_dig%0d: digsel=%b dispout=%h expected %b ef", k, digsel2, dispout2, sel);
      end
    end
    fin_half = 0;
  endtask

  task automatic test_reset_midrun;
    repeat (3) @(negedge CLK);
    #2;
    RSTN = 1'b0;
    #1;
    checks++;
    if (dispout !== 8'h3F || digsel !== 4'b0001 || valid !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: dispout=%h digsel=%b valid=%b ovf=%b expected 3f 0001 0 0",
               dispout, digsel, valid, ovf);
    end
    checks++;
    if (dispout2 !== 8'h3F || digsel2 !== 2'b01 || ovf2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_small: dispout=%h digsel=%b ovf=%b expected 3f 01 0",
               dispout2, digsel2, ovf2);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_steady();
    test_abort();
    test_boundary();
    test_scan();
    test_overflow();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_meter_disp.md
Name: freq_meter_disp

Overview:
- Downstream consumer of the frequency divider's output (QOUT1).
- Counts rising edges of the divided clock over a fixed gate window of CLK cycles.
- Latches the count as NDIG BCD digits and drives a multiplexed 7-segment display.
- Provides the on-board readout that confirms the divider ratio programmed on the A/B/C/D and DN inputs.

Parameters:
- GATE_CYCLES, 100000: gate window length in CLK cycles; minimum 4.
- NDIG, 4: number of BCD digits and display positions.
- REFRESH_DIV, 1000: CLK cycles each digit stays selected during scan; minimum 1.

Ports:
- CLK  in  1  system clock (ring-oscillator clock domain).
- RSTN  in  1  asynchronous active-low reset.
- enable  in  1  active-high measurement enable.
- fin  in  1  divided clock from divider; asynchronous to CLK.
- dispout  out  8  segments {dp,g,f,e,d,c,b,a}, active-high.
- digsel  out  NDIG  one-hot digit select, active-high.
- valid  out  1  one-cycle pulse when a new result is latched.
- ovf  out  1  latched result saturated.

Behaviour:
- Reset (RSTN=0, async) clears everything:
  - edge counter, gate counter, result register, scan counter all 0;
  - digsel = 1 (digit 0); dispout = 8'h3F ("0"); valid = 0; ovf = 0.
- Input capture:
  - fin passes through a 2-flop synchronizer plus one history flop.
  - edge = sync & ~hist. Edge detection latency: 3 CLK cycles.
  - fin high and low times must each be at least 2 CLK cycles; narrower pulses may be missed.
- FSM states:
  - IDLE: enable=0. Gate counter and edge counter held at 0. Result register and ovf retained.
  - COUNT: entered from IDLE on the cycle after enable=1. Gate counter increments every cycle; each edge increments the BCD counter.
  - LATCH: one cycle, entered when gate counter reaches GATE_CYCLES-1. Always returns to COUNT (or IDLE if enable=0).
- LATCH actions:
  - result <= count including any edge on the terminal COUNT cycle.
  - ovf <= saturation flag; valid = 1 for exactly this cycle.
  - Edge counter and saturation flag cleared. An edge arriving during the LATCH cycle counts as 1 in the new window.
- BCD arithmetic:
  - Each digit wraps 9 -> 0 with carry into the next digit, resolved within one cycle.
  - At all-9s plus an edge, the counter saturates at all-9s and sets the saturation flag.
- enable falls mid-window: go to IDLE next cycle and discard the partial count. No valid pulse; displayed result unchanged.
- enable rising again starts a full new window. The first result appears GATE_CYCLES+1 cycles after entering COUNT.
- Scan:
  - Runs regardless of enable. digsel rotates left (wrapping) every REFRESH_DIV cycles.
  - dispout is the combinational decode of the selected digit of result.
  - dp = ovf on every digit.
- Result register update and scan step in the same cycle: the display shows the new result from that cycle onward.

Optional Feature:
- Macro FMETER_LZB_EN.
- When defined: leading-zero blanking. A selected digit more significant than the highest nonzero digit outputs segments 7'h00 (dp still follows ovf). Digit 0 is never blanked.
- When undefined: all digits always shown.

Decomposition:
- Shared package fmeter_pkg holds:
  - BCD digit width constant (4);
  - 7-segment pattern constants for 0-9 plus BLANK;
  - FSM state encoding IDLE/COUNT/LATCH.
- One sub-module, sevenseg_dec: 4-bit BCD in, 7-bit segments out; purely combinational, values 10-15 -> BLANK.

Test Plan (GATE_CYCLES=1000, REFRESH_DIV=4 unless stated):
- Reset: RSTN low mid-run -> immediately dispout=8'h3F, digsel=0001, valid=0, ovf=0.
- Steady count: fin period 10 CLK, enable=1 -> valid every 1001 cycles; result digits 0,1,0,0 (=100); ovf=0.
- Overflow: fin period 4 CLK with GATE_CYCLES=100000 -> 25000 edges; result saturates 9999, ovf=1, dp set on all digits.
- Abort: enable dropped at gate 500 -> no valid pulse, previous result held. Re-enable -> next valid after 1001 cycles with a full count.
- Boundary edge: edge on terminal COUNT cycle -> included in latched value. Edge during LATCH -> new window starts at 1.
- Scan/LZB: result 0042 -> digsel sequence 0001,0010,0100,1000, each held 4 cycles. With FMETER_LZB_EN, digits 2-3 -> 8'h00; without it -> 8'h3F.
